// File: rtl/mem_responder_pkg.sv
// Shared state encoding and address-geometry helpers for the main-memory responder.
// Used by both the responder top and its block store.
package mem_responder_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WRITE_WAIT = 2'd1,
        READ_WAIT  = 2'd2
    } state_e;

    localparam int LATENCY_CNT_W      = 8;
    localparam int DEFAULT_BLOCK_SIZE = 32;

    function automatic int blockWidth(input int blockSize);
        return 8 * blockSize;
    endfunction

    function automatic int offsetBits(input int blockSize);
        return $clog2(blockSize);
    endfunction

    function automatic int indexBits(input int depth);
        return $clog2(depth);
    endfunction

    localparam int DEFAULT_BLOCK_W = blockWidth(DEFAULT_BLOCK_SIZE);

    typedef logic [DEFAULT_BLOCK_W-1:0] block_t;

endpackage

// File: rtl/mem_responder_block_store.sv
// Single-port block-wide backing store: synchronous write, registered read.
// The array itself is never reset; only the read register is.
module mem_block_store
    import mem_responder_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int WIDTH = 256
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic [indexBits(DEPTH)-1:0] index_i,
    input  logic                        wrEn_i,
    input  logic [WIDTH-1:0]            wrData_i,
    input  logic                        rdEn_i,
    output logic [WIDTH-1:0]            rdData_o
);

    logic [WIDTH-1:0] memArray_q [DEPTH];
    logic [WIDTH-1:0] rdData_q;

    always_ff @(posedge clk_i) begin
        if (wrEn_i) begin
            memArray_q[index_i] <= wrData_i;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rdData_q <= '0;
        end else if (rdEn_i) begin
            rdData_q <= memArray_q[index_i];
        end
    end

    assign rdData_o = rdData_q;

endmodule

// File: rtl/main_memory_responder.sv
// Main-memory end of the cache fetch/write-back path with fixed LATENCY response.
// Optional out-of-range detection and accessError port: define MEM_RESPONDER_ERR_EN.
module main_memory_responder
    import mem_responder_pkg::*;
#(
    parameter int BLOCK_SIZE    = 32,
    parameter int ADDRESS_WIDTH = 32,
    parameter int DEPTH         = 64,
    parameter int LATENCY       = 4
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      fetchRequest_i,
    input  logic [ADDRESS_WIDTH-1:0]  fetchAddress_i,
    output logic [8*BLOCK_SIZE-1:0]   fetchedData_o,
    output logic                      fetchValid_o,
    input  logic                      writeBackRequest_i,
    input  logic [ADDRESS_WIDTH-1:0]  writeBackAddress_i,
    input  logic [8*BLOCK_SIZE-1:0]   writeBackData_i,
    output logic                      writeBackDone_o,
    output logic                      busy_o
`ifdef MEM_RESPONDER_ERR_EN
    ,
    output logic                      accessError_o
`endif
);

    localparam int OFFSET_BITS  = offsetBits(BLOCK_SIZE);
    localparam int INDEX_BITS   = indexBits(DEPTH);
    localparam int BLOCK_W      = blockWidth(BLOCK_SIZE);
    localparam bit SINGLE_CYCLE = (LATENCY == 1);
    localparam logic [LATENCY_CNT_W-1:0] CNT_RELOAD = LATENCY_CNT_W'(LATENCY - 1);
    localparam logic [LATENCY_CNT_W-1:0] CNT_ONE    = LATENCY_CNT_W'(1);

    state_e                     state_q;
    logic [LATENCY_CNT_W-1:0]   cnt_q;
    logic                       busy_q;
    logic                       fetchValid_q;
    logic                       wbDone_q;
    logic                       pending_q;
    logic [ADDRESS_WIDTH-1:0]   addr_q;
    logic [ADDRESS_WIDTH-1:0]   pendAddr_q;
    logic [BLOCK_W-1:0]         wrData_q;

    logic                       accept;
    logic                       waitDone;
    logic                       startWrite;
    logic                       startRead;
    logic                       fireWrite;
    logic                       fireRead;
    logic [ADDRESS_WIDTH-1:0]   wrAddr;
    logic [ADDRESS_WIDTH-1:0]   rdAddr;
    logic [BLOCK_W-1:0]         wrData;
    logic [INDEX_BITS-1:0]      storeIndex;
    logic                       wrOutOfRange;
    logic [BLOCK_W-1:0]         storeRdData;
    logic                       unusedAddrBits;

    // A response pulse is registered one edge before the counter would hit zero,
    // so the pulse cycle is the one where the counter reads 0; LATENCY=1 fires on accept.
    always_comb begin
        accept     = (state_q == IDLE) && (fetchRequest_i || writeBackRequest_i);
        waitDone   = (state_q != IDLE) && (cnt_q == '0);
        startWrite = accept && writeBackRequest_i;
        startRead  = (accept && !writeBackRequest_i)
                   || (waitDone && (state_q == WRITE_WAIT) && pending_q);
        fireWrite  = (startWrite && SINGLE_CYCLE) || ((state_q == WRITE_WAIT) && (cnt_q == CNT_ONE));
        fireRead   = (startRead && SINGLE_CYCLE) || ((state_q == READ_WAIT) && (cnt_q == CNT_ONE));
        wrAddr     = (state_q == IDLE) ? writeBackAddress_i : addr_q;
        wrData     = (state_q == IDLE) ? writeBackData_i : wrData_q;
        case (state_q)
            IDLE:       rdAddr = fetchAddress_i;
            WRITE_WAIT: rdAddr = pendAddr_q;
            default:    rdAddr = addr_q;
        endcase
        storeIndex = fireWrite ? wrAddr[OFFSET_BITS +: INDEX_BITS]
                               : rdAddr[OFFSET_BITS +: INDEX_BITS];
    end

    assign unusedAddrBits = ^{wrAddr, rdAddr};

    // Sequencer: a simultaneous fetch waits in the pending slot behind the write-back.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            busy_q       <= 1'b0;
            fetchValid_q <= 1'b0;
            wbDone_q     <= 1'b0;
            pending_q    <= 1'b0;
            addr_q       <= '0;
            pendAddr_q   <= '0;
            wrData_q     <= '0;
        end else begin
            fetchValid_q <= fireRead;
            wbDone_q     <= fireWrite;
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        busy_q <= 1'b1;
                        cnt_q  <= CNT_RELOAD;
                        if (writeBackRequest_i) begin
                            state_q    <= WRITE_WAIT;
                            addr_q     <= writeBackAddress_i;
                            wrData_q   <= writeBackData_i;
                            pending_q  <= fetchRequest_i;
                            pendAddr_q <= fetchAddress_i;
                        end else begin
                            state_q <= READ_WAIT;
                            addr_q  <= fetchAddress_i;
                        end
                    end
                end
                default: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end else if (startRead) begin
                        state_q   <= READ_WAIT;
                        addr_q    <= pendAddr_q;
                        pending_q <= 1'b0;
                        cnt_q     <= CNT_RELOAD;
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
            endcase
        end
    end

`ifdef MEM_RESPONDER_ERR_EN
    localparam int USED_BITS = OFFSET_BITS + INDEX_BITS;

    logic rdOutOfRange;
    logic zeroData_q;
    logic accessError_q;

    assign wrOutOfRange = (wrAddr >> USED_BITS) != '0;
    assign rdOutOfRange = (rdAddr >> USED_BITS) != '0;

    // An out-of-range fetch returns zeros, held until the next fetch response.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            zeroData_q    <= 1'b0;
            accessError_q <= 1'b0;
        end else begin
            accessError_q <= (fireWrite && wrOutOfRange) || (fireRead && rdOutOfRange);
            if (fireRead) begin
                zeroData_q <= rdOutOfRange;
            end
        end
    end

    assign accessError_o = accessError_q;
    assign fetchedData_o = zeroData_q ? '0 : storeRdData;
`else
    assign wrOutOfRange  = 1'b0;
    assign fetchedData_o = storeRdData;
`endif

    mem_block_store #(
        .DEPTH (DEPTH),
        .WIDTH (BLOCK_W)
    ) u_store (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .index_i  (storeIndex),
        .wrEn_i   (fireWrite && !wrOutOfRange),
        .wrData_i (wrData),
        .rdEn_i   (fireRead),
        .rdData_o (storeRdData)
    );

    assign fetchValid_o    = fetchValid_q;
    assign writeBackDone_o = wbDone_q;
    assign busy_o          = busy_q;

endmodule

// File: tb/tb_main_memory_responder.sv
// Self-checking bench for main_memory_responder against a transaction-level memory model.
// Exercises the accessError port as well when MEM_RESPONDER_ERR_EN is defined.
module tb_main_memory_responder;

    localparam int LAT     = 4;
    localparam int BW      = 256;
    localparam int AW      = 32;
    localparam int TRACE_N = 12;
`ifdef MEM_RESPONDER_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          fetchRequest;
    logic [AW-1:0] fetchAddress;
    logic [BW-1:0] fetchedData;
    logic          fetchValid;
    logic          writeBackRequest;
    logic [AW-1:0] writeBackAddress;
    logic [BW-1:0] writeBackData;
    logic          writeBackDone;
    logic          busy;
    logic          accessError;

    int checks = 0;
    int errors = 0;

    logic [BW-1:0] modelMem [64];
    logic [BW-1:0] lastFetched;

    logic          busyTr  [TRACE_N+1];
    logic          validTr [TRACE_N+1];
    logic          doneTr  [TRACE_N+1];
    logic          errTr   [TRACE_N+1];
    logic [BW-1:0] dataTr  [TRACE_N+1];

    always #5 clk = ~clk;

    main_memory_responder #(
        .BLOCK_SIZE    (32),
        .ADDRESS_WIDTH (AW),
        .DEPTH         (64),
        .LATENCY       (LAT)
    ) dut (
        .clk_i              (clk),
        .reset_i            (reset),
        .fetchRequest_i     (fetchRequest),
        .fetchAddress_i     (fetchAddress),
        .fetchedData_o      (fetchedData),
        .fetchValid_o       (fetchValid),
        .writeBackRequest_i (writeBackRequest),
        .writeBackAddress_i (writeBackAddress),
        .writeBackData_i    (writeBackData),
        .writeBackDone_o    (writeBackDone),
        .busy_o             (busy)
`ifdef MEM_RESPONDER_ERR_EN
        ,
        .accessError_o      (accessError)
`endif
    );

`ifndef MEM_RESPONDER_ERR_EN
    assign accessError = 1'b0;
`endif

    function automatic int idxOf(input logic [AW-1:0] a);
        return int'(a[5 +: 6]);
    endfunction

    function automatic bit outOfRange(input logic [AW-1:0] a);
        return ERR_EN && ((a >> 11) != 0);
    endfunction

    function automatic logic [BW-1:0] randBlock();
        logic [BW-1:0] r;
        for (int i = 0; i < BW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Records outputs for n cycles following a request driven in the current cycle.
    task automatic captureTrace(input int n);
        for (int j = 1; j <= n; j++) begin
            @(negedge clk);
            if (j == 1) begin
                fetchRequest     = 1'b0;
                writeBackRequest = 1'b0;
            end
            busyTr[j]  = busy;
            validTr[j] = fetchValid;
            doneTr[j]  = writeBackDone;
            errTr[j]   = accessError;
            dataTr[j]  = fetchedData;
        end
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [BW-1:0] d);
        writeBackRequest = 1'b1;
        writeBackAddress = a;
        writeBackData    = d;
        captureTrace(LAT + 1);
        if (!outOfRange(a)) modelMem[idxOf(a)] = d;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        fetchRequest = 1'b0; writeBackRequest = 1'b0;
        fetchAddress = '0; writeBackAddress = '0; writeBackData = '0;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (fetchValid !== 1'b0) begin errors++; $display("[TB] FAIL reset_fetchValid: got %b expected 0", fetchValid); end
        checks++; if (writeBackDone !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", writeBackDone); end
        checks++; if (fetchedData !== '0) begin errors++; $display("[TB] FAIL reset_data: got %h expected 0", fetchedData); end
        checks++; if (accessError !== 1'b0) begin errors++; $display("[TB] FAIL reset_err: got %b expected 0", accessError); end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL idle_busy: got %b expected 0", busy); end
        lastFetched = '0;
    endtask

    task automatic test_fetch_after_preload;
        logic [BW-1:0] pat;
        pat = {32{8'hA5}};
        preload(32'h0000_0040, pat);
        fetchRequest = 1'b1; fetchAddress = 32'h0000_0040;
        captureTrace(LAT + 2);
        for (int j = 1; j <= LAT + 2; j++) begin
            checks++; if (busyTr[j] !== (j <= LAT)) begin errors++; $display("[TB] FAIL preload_busy cycle %0d: got %b expected %b", j, busyTr[j], j <= LAT); end
            checks++; if (validTr[j] !== (j == LAT)) begin errors++; $display("[TB] FAIL preload_valid cycle %0d: got %b expected %b", j, validTr[j], j == LAT); end
            if (j >= LAT) begin
                checks++; if (dataTr[j] !== pat) begin errors++; $display("[TB] FAIL preload_data cycle %0d: got %h expected %h", j, dataTr[j], pat); end
            end
        end
        lastFetched = pat;
    endtask

    task automatic test_write_then_read;
        logic [BW-1:0] ramp;
        for (int b = 0; b < 32; b++) ramp[b*8 +: 8] = 8'(b);
        writeBackRequest = 1'b1; writeBackAddress = 32'h0000_0060; writeBackData = ramp;
        captureTrace(LAT + 1);
        modelMem[idxOf(32'h60)] = ramp;
        for (int j = 1; j <= LAT + 1; j++) begin
            checks++; if (doneTr[j] !== (j == LAT)) begin errors++; $display("[TB] FAIL wr_done cycle %0d: got %b expected %b", j, doneTr[j], j == LAT); end
            checks++; if (validTr[j] !== 1'b0) begin errors++; $display("[TB] FAIL wr_no_valid cycle %0d: got %b expected 0", j, validTr[j]); end
            checks++; if (busyTr[j] !== (j <= LAT)) begin errors++; $display("[TB] FAIL wr_busy cycle %0d: got %b expected %b", j, busyTr[j], j <= LAT); end
        end
        fetchRequest = 1'b1; fetchAddress = 32'h0000_0060;
        captureTrace(LAT + 1);
        for (int j = 1; j <= LAT + 1; j++) begin
            checks++; if (validTr[j] !== (j == LAT)) begin errors++; $display("[TB] FAIL rd_valid cycle %0d: got %b expected %b", j, validTr[j], j == LAT); end
        end
        checks++; if (dataTr[LAT] !== ramp) begin errors++; $display("[TB] FAIL rd_ramp: got %h expected %h", dataTr[LAT], ramp); end
        lastFetched = ramp;
    endtask

    task automatic test_simultaneous;
        logic [BW-1:0] oldData, newData;
        oldData = randBlock();
        newData = ~oldData;
        preload(32'h0000_0020, oldData);
        fetchRequest = 1'b1; fetchAddress = 32'h0000_0020;
        writeBackRequest = 1'b1; writeBackAddress = 32'h0000_0020; writeBackData = newData;
        captureTrace(2 * LAT + 1);
        modelMem[idxOf(32'h20)] = newData;
        for (int j = 1; j <= 2 * LAT + 1; j++) begin
            checks++; if (busyTr[j] !== (j <= 2 * LAT)) begin errors++; $display("[TB] FAIL both_busy cycle %0d: got %b expected %b", j, busyTr[j], j <= 2 * LAT); end
            checks++; if (doneTr[j] !== (j == LAT)) begin errors++; $display("[TB] FAIL both_done cycle %0d: got %b expected %b", j, doneTr[j], j == LAT); end
            checks++; if (validTr[j] !== (j == 2 * LAT)) begin errors++; $display("[TB] FAIL both_valid cycle %0d: got %b expected %b", j, validTr[j], j == 2 * LAT); end
        end
        checks++; if (dataTr[2 * LAT] !== newData) begin errors++; $display("[TB] FAIL both_data: got %h expected %h", dataTr[2 * LAT], newData); end
        lastFetched = newData;
    endtask

    task automatic test_busy_ignore;
        logic [BW-1:0] dataA, dataB;
        dataA = randBlock();
        dataB = randBlock();
        preload(32'h0000_0080, dataA);
        preload(32'h0000_00A0, dataB);
        fetchRequest = 1'b1; fetchAddress = 32'h0000_0080;
        for (int j = 1; j <= LAT + 4; j++) begin
            @(negedge clk);
            fetchRequest = (j == 2);
            fetchAddress = (j == 2) ? 32'h0000_00A0 : 32'h0000_0080;
            checks++; if (fetchValid !== (j == LAT)) begin errors++; $display("[TB] FAIL busy_ign_valid cycle %0d: got %b expected %b", j, fetchValid, j == LAT); end
            checks++; if (busy !== (j <= LAT)) begin errors++; $display("[TB] FAIL busy_ign_busy cycle %0d: got %b expected %b", j, busy, j <= LAT); end
            if (j >= LAT) begin
                checks++; if (fetchedData !== dataA) begin errors++; $display("[TB] FAIL busy_ign_data cycle %0d: got %h expected %h", j, fetchedData, dataA); end
            end
        end
        fetchRequest = 1'b1; fetchAddress = 32'h0000_00A0;
        captureTrace(LAT + 1);
        checks++; if (validTr[LAT] !== 1'b1) begin errors++; $display("[TB] FAIL busy_ign_b_valid: got %b expected 1", validTr[LAT]); end
        checks++; if (dataTr[LAT] !== dataB) begin errors++; $display("[TB] FAIL busy_ign_b_data: got %h expected %h", dataTr[LAT], dataB); end
        lastFetched = dataB;
    endtask

    task automatic test_reset_mid_write;
        logic [BW-1:0] prior;
        prior = modelMem[idxOf(32'h60)];
        writeBackRequest = 1'b1; writeBackAddress = 32'h0000_0060; writeBackData = ~prior;
        @(negedge clk);
        writeBackRequest = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL midrst_busy_before: got %b expected 1", busy); end
        reset = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL midrst_busy: got %b expected 0", busy); end
        checks++; if (writeBackDone !== 1'b0) begin errors++; $display("[TB] FAIL midrst_done: got %b expected 0", writeBackDone); end
        checks++; if (fetchedData !== '0) begin errors++; $display("[TB] FAIL midrst_data: got %h expected 0", fetchedData); end
        @(negedge clk);
        reset = 1'b0;
        for (int j = 0; j < LAT + 2; j++) begin
            @(negedge clk);
            checks++; if (writeBackDone !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL midrst_quiet cycle %0d: got done=%b busy=%b expected 0 0", j, writeBackDone, busy); end
        end
        fetchRequest = 1'b1; fetchAddress = 32'h0000_0060;
        captureTrace(LAT + 1);
        checks++; if (validTr[LAT] !== 1'b1) begin errors++; $display("[TB] FAIL midrst_fetch_valid: got %b expected 1", validTr[LAT]); end
        checks++; if (dataTr[LAT] !== prior) begin errors++; $display("[TB] FAIL midrst_prior_data: got %h expected %h", dataTr[LAT], prior); end
        lastFetched = prior;
    endtask

`ifdef MEM_RESPONDER_ERR_EN
    task automatic test_access_error;
        logic [BW-1:0] keep;
        fetchRequest = 1'b1; fetchAddress = 32'h0000_0800;
        captureTrace(LAT + 1);
        for (int j = 1; j <= LAT + 1; j++) begin
            checks++; if (validTr[j] !== (j == LAT)) begin errors++; $display("[TB] FAIL err_fetch_valid cycle %0d: got %b expected %b", j, validTr[j], j == LAT); end
            checks++; if (errTr[j] !== (j == LAT)) begin errors++; $display("[TB] FAIL err_fetch_err cycle %0d: got %b expected %b", j, errTr[j], j == LAT); end
        end
        checks++; if (dataTr[LAT] !== '0) begin errors++; $display("[TB] FAIL err_fetch_data: got %h expected 0", dataTr[LAT]); end
        keep = modelMem[idxOf(32'h60)];
        writeBackRequest = 1'b1; writeBackAddress = 32'h0000_0860; writeBackData = ~keep;
        captureTrace(LAT + 1);
        checks++; if (doneTr[LAT] !== 1'b1 || errTr[LAT] !== 1'b1) begin errors++; $display("[TB] FAIL err_write_pulse: got done=%b err=%b expected 1 1", doneTr[LAT], errTr[LAT]); end
        fetchRequest = 1'b1; fetchAddress = 32'h0000_0060;
        captureTrace(LAT + 1);
        checks++; if (dataTr[LAT] !== keep) begin errors++; $display("[TB] FAIL err_write_suppressed: got %h expected %h", dataTr[LAT], keep); end
        lastFetched = keep;
    endtask
`endif

    task automatic test_random;
        for (int i = 0; i < 64; i++) preload(AW'(i) << 5, randBlock());
        for (int t = 0; t < 50; t++) begin
            int            kind, wT, fT, endT;
            bit            doF, doW, oorF, oorW;
            logic [AW-1:0] fa, wa;
            logic [BW-1:0] wd, expF, expData;
            kind = $urandom_range(0, 2);
            doF  = (kind != 1);
            doW  = (kind != 0);
            if (ERR_EN) begin
                fa = ($urandom_range(0, 7) != 0) ? ($urandom & 32'h7FF) : ($urandom | 32'h800);
                wa = ($urandom_range(0, 7) != 0) ? ($urandom & 32'h7FF) : ($urandom | 32'h800);
            end else begin
                fa = $urandom;
                wa = $urandom;
            end
            if (doF && doW && $urandom_range(0, 1) == 1) wa = fa;
            wd   = randBlock();
            oorF = outOfRange(fa);
            oorW = outOfRange(wa);
            wT   = doW ? LAT : 0;
            fT   = doF ? (doW ? 2 * LAT : LAT) : 0;
            endT = (wT > fT) ? wT : fT;
            if (doW && !oorW) modelMem[idxOf(wa)] = wd;
            expF = oorF ? '0 : modelMem[idxOf(fa)];
            fetchRequest = doF; fetchAddress = fa;
            writeBackRequest = doW; writeBackAddress = wa; writeBackData = wd;
            captureTrace(endT + 1);
            for (int j = 1; j <= endT + 1; j++) begin
                expData = (doF && j >= fT) ? expF : lastFetched;
                checks++; if (busyTr[j] !== (j <= endT)) begin errors++; $display("[TB] FAIL rnd%0d_busy cycle %0d: got %b expected %b", t, j, busyTr[j], j <= endT); end
                checks++; if (validTr[j] !== (doF && j == fT)) begin errors++; $display("[TB] FAIL rnd%0d_valid cycle %0d: got %b expected %b", t, j, validTr[j], doF && j == fT); end
                checks++; if (doneTr[j] !== (doW && j == wT)) begin errors++; $display("[TB] FAIL rnd%0d_done cycle %0d: got %b expected %b", t, j, doneTr[j], doW && j == wT); end
                checks++; if (errTr[j] !== ((doW && j == wT && oorW) || (doF && j == fT && oorF))) begin errors++; $display("[TB] FAIL rnd%0d_err cycle %0d: got %b", t, j, errTr[j]); end
                checks++; if (dataTr[j] !== expData) begin errors++; $display("[TB] FAIL rnd%0d_data cycle %0d: got %h expected %h", t, j, dataTr[j], expData); end
            end
            if (doF) lastFetched = expF;
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_fetch_after_preload();
        test_write_then_read();
        test_simultaneous();
        test_busy_ignore();
        test_reset_mid_write();
`ifdef MEM_RESPONDER_ERR_EN
        test_access_error();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
